// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: decode-side tag pipeline, operand/SP forwarding
// selects and load-use stall control.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   id_valid        valid instruction in ID
//   id_src          source indices, operand i at [i*REG_AW +: REG_AW]
//   id_src_used     operand i reads a register
//   id_dst, id_wb   destination index and its write enable
//   id_load         instruction is a memory load
//   id_sp_use/id_sp_w  instruction reads / writes SP
//   flush           squash from EX (branch or interrupt)
//   stall_id        hold PC and IF/ID
//   bubble_ex       insert NOP into ID/EX
//   fwd_sel         per operand: 00 regfile, 10 MEM, 01 WB
//   sp_sel          SP select: 00 SP register, 10 MEM, 01 WB
// Optional (macro HAZARD_PERF_EN):
//   perf_stall_cnt  saturating count of stall_id cycles
//   perf_flush_cnt  saturating count of flush cycles
module hazard_fwd_unit #(
    parameter int REG_AW   = 3,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [REG_AW-1:0]          id_dst,
    input  logic                       id_wb,
    input  logic                       id_load,
    input  logic                       id_sp_use,
    input  logic                       id_sp_w,
    input  logic                       flush,
    output logic                       stall_id,
    output logic                       bubble_ex,
    output logic [2*NUM_SRC-1:0]       fwd_sel,
    output logic [1:0]                 sp_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_flush_cnt
`endif
);

    localparam int SW = NUM_SRC * REG_AW;

    // Extra stall cycles beyond the detection cycle for an EX-stage load.
    localparam logic [1:0] H1_EXTRA = 2'(LOAD_LAT - 1);

    typedef struct packed {
        logic               valid;
        logic [SW-1:0]      src;
        logic [NUM_SRC-1:0] src_used;
        logic [REG_AW-1:0]  dst;
        logic               wb;
        logic               load;
        logic               sp_use;
        logic               sp_w;
    } tag_t;

    typedef enum logic {
        RUN,
        STALL
    } state_t;

    tag_t              id_tag;
    tag_t              ex_q;
    tag_t              mem_q;
    tag_t              wb_q;
    state_t            state_q;
    state_t            state_d;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              ex_hit;
    logic              mem_hit;
    logic              h1;
    logic              h2;
    logic [REG_AW-1:0] ex_src;
    logic              unused_tag_bits;

    // Not every stage needs every field.
    assign unused_tag_bits = ^{ex_q, mem_q, wb_q};

    always_comb begin
        id_tag          = '0;
        id_tag.valid    = id_valid && !bubble_ex;
        id_tag.src      = id_src;
        id_tag.src_used = id_src_used;
        id_tag.dst      = id_dst;
        id_tag.wb       = id_wb;
        id_tag.load     = id_load;
        id_tag.sp_use   = id_sp_use;
        id_tag.sp_w     = id_sp_w;
    end

    always_comb begin
        ex_hit  = 1'b0;
        mem_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i]) begin
                if (id_src[i*REG_AW +: REG_AW] == ex_q.dst)
                    ex_hit = 1'b1;
                if (id_src[i*REG_AW +: REG_AW] == mem_q.dst)
                    mem_hit = 1'b1;
            end
        end
    end

    assign h1 = id_valid && ex_q.valid && ex_q.wb
             && ex_q.load && ex_hit;

    // A load one stage further on still needs a bubble when the
    // load result is two cycles away.
    assign h2 = (LOAD_LAT == 2) && id_valid && mem_q.valid
             && mem_q.wb && mem_q.load && mem_hit && !h1;

    // MEM holds the younger producer, so it wins over WB.
    always_comb begin
        fwd_sel = '0;
        ex_src  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ex_src = ex_q.src[i*REG_AW +: REG_AW];
            if (ex_q.valid && ex_q.src_used[i]) begin
                if (mem_q.valid && mem_q.wb && mem_q.dst == ex_src)
                    fwd_sel[2*i +: 2] = 2'b10;
                else if (wb_q.valid && wb_q.wb && wb_q.dst == ex_src)
                    fwd_sel[2*i +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        sp_sel = 2'b00;
        if (ex_q.valid && ex_q.sp_use) begin
            if (mem_q.valid && mem_q.sp_w)
                sp_sel = 2'b10;
            else if (wb_q.valid && wb_q.sp_w)
                sp_sel = 2'b01;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        if (flush) begin
            bubble_ex = 1'b1;
            state_d   = RUN;
            cnt_d     = 2'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    unique case (1'b1)
                        h1: begin
                            stall_id  = 1'b1;
                            bubble_ex = 1'b1;
                            cnt_d     = H1_EXTRA;
                            state_d   = (H1_EXTRA != 2'd0) ? STALL : RUN;
                        end
                        h2: begin
                            stall_id  = 1'b1;
                            bubble_ex = 1'b1;
                            cnt_d     = 2'd0;
                        end
                        default: ;
                    endcase
                end
                STALL: begin
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    // cnt counts remaining stall cycles including this one.
                    if (cnt_q <= 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            ex_q    <= id_tag;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_id && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised successor to the decode-stage forwarding unit. It tracks in-flight destination tags for the EX, MEM and WB stages in an internal shift pipeline. From those tags it generates per-operand and SP forwarding selects for the instruction in EX, and it detects load-use hazards, stalling IF/ID and injecting EX bubbles for a configurable load latency. Sits in Decode beside the register file and drives the EX operand muxes and the IF/ID hold and ID/EX bubble controls.

Parameters:
REG_AW, 3, register address width (2^REG_AW GPRs, all writable, no hardwired zero)
NUM_SRC, 2, number of source operands per instruction
LOAD_LAT, 1, load-use bubbles required for a dependent in the next slot; legal 1..2

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  valid instruction in ID
id_src  in  NUM_SRC*REG_AW  source register indices, operand i at [i*REG_AW +: REG_AW]
id_src_used  in  NUM_SRC  operand i actually reads a register
id_dst  in  REG_AW  destination index
id_wb  in  1  instruction writes id_dst
id_load  in  1  instruction is a memory load
id_sp_use  in  1  instruction reads SP
id_sp_w  in  1  instruction writes SP
flush  in  1  branch or interrupt squash from EX
stall_id  out  1  hold PC and IF/ID
bubble_ex  out  1  insert NOP into ID/EX
fwd_sel  out  2*NUM_SRC  per-operand select for EX instruction: 00 regfile, 10 MEM-stage result, 01 WB-stage result
sp_sel  out  2  SP select for EX instruction: 00 SP register, 10 MEM, 01 WB

Behaviour:
- Tag pipeline: three entries EX, MEM and WB. Each entry holds valid, src[], src_used[], dst, wb, load, sp_use, sp_w. It advances every clock: WB<=MEM, MEM<=EX, EX<=ID.
- The EX entry loads ID fields only when id_valid && !bubble_ex. Otherwise EX.valid<=0.
- Reset: all entry valids 0, FSM=RUN, counter 0. As a consequence, stall_id=0, bubble_ex=0, fwd_sel=0 and sp_sel=0 on the first cycle after reset.
- fwd_sel[i] (combinational from EX entry):
  - 00 if !EX.valid or !EX.src_used[i].
  - Else 10 if MEM.valid && MEM.wb && MEM.dst==EX.src[i]. MEM has priority because it is younger.
  - Else 01 if WB.valid && WB.wb && WB.dst==EX.src[i].
  - Else 00.
- sp_sel uses the same priority with sp_w in place of wb/dst match, gated by EX.sp_use.
- Hazard h1: id_valid && EX.valid && EX.wb && EX.load && some used id_src==EX.dst. Required stall: LOAD_LAT cycles.
- Hazard h2 (LOAD_LAT=2 only): id_valid && MEM.valid && MEM.wb && MEM.load && some used id_src==MEM.dst, with no h1. Required stall: 1 cycle.
- Register file writes in first half-cycle, so a value retired past WB reads correctly from the regfile.
- FSM:
  - RUN:
    - flush → bubble_ex=1, stall_id=0, stay RUN.
    - h1 or h2 → stall_id=1, bubble_ex=1 in the detection cycle; cnt<=required-1; go STALL if required>1.
    - Otherwise no stall.
  - STALL:
    - stall_id=1, bubble_ex=1, cnt decrements.
    - Go RUN when cnt==0 at the clock edge. Hazards are re-evaluated in RUN the next cycle.
- Total stall for h1 is exactly LOAD_LAT cycles.
- flush has priority over stall in any state: stall_id=0, bubble_ex=1, FSM<=RUN, cnt<=0.
- rst mid-stall: FSM returns to RUN, and stall_id is 0 in the cycle after the reset edge.
- A non-load producer never stalls; it is covered by forwarding.
- id_valid=0 never stalls.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds output perf_stall_cnt (32) and output perf_flush_cnt (32).
  - perf_stall_cnt increments every cycle stall_id=1.
  - perf_flush_cnt increments every cycle flush=1.
  - Both counters saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: ports and counters absent; no other behaviour changes.

Test Plan:
- ADD R1 (wb, dst=1), then ADD using src0=1 next cycle → when consumer in EX, fwd_sel[1:0]=10, no stall.
- Producer dst=3, one unrelated instr, consumer src1=3 → fwd_sel[3:2]=01.
- Producers dst=2 in both MEM and WB, consumer src0=2 → fwd_sel[1:0]=10 (MEM wins).
- LOAD_LAT=1: LDD dst=4, next instr src0=4 → stall_id=1 and bubble_ex=1 for exactly 1 cycle, then fwd_sel[1:0]=01.
- LOAD_LAT=2: LDD dst=4 followed by dependent → 2 stall cycles. Same load with one independent instruction between → 1 stall cycle.
- Load-use stall in progress (LOAD_LAT=2, cycle 1) with flush=1 → stall_id=0, bubble_ex=1 that cycle, FSM RUN next cycle. rst asserted instead → all outputs 0 the following cycle.
- PUSH (sp_w) then POP (sp_use) → sp_sel=10. With one gap → sp_sel=01.
